// File: rtl/heater_pwm_driver.sv
// Fixed-period heater PWM driven by the coprocessor's G_out command.
// Applies slew limiting once per period and falls back to a safe duty if the commands stop arriving.
module heater_pwm_driver #(
    parameter int PERIOD       = 1000,
    parameter int SLEW_MAX     = 10,
    parameter int WDOG_PERIODS = 8,
    parameter int SAFE_DUTY    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       g_valid,
    input  logic [7:0] g_in,
    output logic       pwm_out,
    output logic       period_tick,
    output logic [7:0] duty_applied,
    output logic       wdog_fault,
    output logic       clamp_err
);

    localparam int                WW        = $clog2(WDOG_PERIODS + 1);
    localparam logic [15:0]       LAST      = 16'(PERIOD - 1);
    localparam logic [WW-1:0]     WDOG_MAX  = WW'(WDOG_PERIODS);
    localparam logic signed [9:0] SLEW      = 10'(SLEW_MAX);
    localparam logic [7:0]        SAFE      = 8'(SAFE_DUTY);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAILSAFE
    } state_t;

    state_t            state;
    logic [15:0]       cnt;
    logic [15:0]       thr;
    logic [7:0]        pending;
    logic [WW-1:0]     wdog_cnt;
    logic              seen;

    logic              boundary;
    logic              trip;
    logic [WW-1:0]     wdog_inc;
    logic [WW-1:0]     wdog_at_bnd;
    logic [7:0]        target;
    logic signed [9:0] delta;
    logic [7:0]        duty_next;
    logic [23:0]       prod;
    logic [15:0]       thr_next;
    logic [7:0]        g_clamped;

    // NOTE: every always_comb output gets a value on every path (here up front) so no latch is inferred.
    always_comb begin
        boundary    = (state != IDLE) && enable && (cnt == LAST);
        wdog_inc    = (wdog_cnt == WDOG_MAX) ? wdog_cnt : wdog_cnt + WW'(1);
        // A strobe on the boundary cycle clears the count rather than letting it advance.
        wdog_at_bnd = g_valid ? '0 : (seen ? wdog_cnt : wdog_inc);
        trip        = boundary && (state == RUN) && (wdog_at_bnd == WDOG_MAX);
        target      = ((state == FAILSAFE) || trip) ? SAFE : pending;

        delta = $signed({2'b00, target}) - $signed({2'b00, duty_applied});
        if (SLEW_MAX > 0) begin
            if (delta > SLEW) begin
                delta = SLEW;
            end else if (delta < -SLEW) begin
                delta = -SLEW;
            end
        end
        // Result stays within 0..100, so modulo-256 addition is exact.
        duty_next = duty_applied + delta[7:0];
        prod      = 24'(duty_next) * 24'(PERIOD);
        thr_next  = 16'(prod / 24'd100);
        g_clamped = (g_in > 8'd100) ? 8'd100 : g_in;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            thr          <= '0;
            pending      <= '0;
            wdog_cnt     <= '0;
            seen         <= 1'b0;
            pwm_out      <= 1'b0;
            period_tick  <= 1'b0;
            duty_applied <= '0;
            wdog_fault   <= 1'b0;
            clamp_err    <= 1'b0;
        end else begin
            clamp_err <= g_valid && (g_in > 8'd100);

            if (g_valid) begin
                pending    <= g_clamped;
                wdog_fault <= 1'b0;
            end

            // seen remembers a strobe since the last boundary; a boundary strobe counts for the next period.
            if (boundary) begin
                seen     <= g_valid;
                wdog_cnt <= wdog_at_bnd;
            end else if (g_valid) begin
                seen     <= 1'b1;
                wdog_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state       <= RUN;
                        cnt         <= '0;
                        period_tick <= 1'b1;
                        pwm_out     <= (thr != 16'd0);
                    end else begin
                        period_tick <= 1'b0;
                        pwm_out     <= 1'b0;
                    end
                end

                RUN, FAILSAFE: begin
                    if (!enable) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        period_tick <= 1'b0;
                        pwm_out     <= 1'b0;
                    end else if (boundary) begin
                        cnt          <= '0;
                        period_tick  <= 1'b1;
                        duty_applied <= duty_next;
                        thr          <= thr_next;
                        pwm_out      <= (thr_next != 16'd0);
                        if (trip) begin
                            state      <= FAILSAFE;
                            wdog_fault <= 1'b1;
                        end else if ((state == FAILSAFE) && g_valid) begin
                            state <= RUN;
                        end
                    end else begin
                        cnt         <= cnt + 16'd1;
                        period_tick <= 1'b0;
                        pwm_out     <= ((cnt + 16'd1) < thr);
                        if ((state == FAILSAFE) && g_valid) begin
                            state <= RUN;
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    period_tick <= 1'b0;
                    pwm_out     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_heater_pwm_driver.sv
// Bench for heater_pwm_driver: directed period-level sequences, a vector table on a
// no-slew instance, and a randomized run against a period-level reference model.
module tb_heater_pwm_driver;

    localparam int PA     = 100;
    localparam int PB     = 250;
    localparam int SLEW_A = 10;
    localparam int WD     = 4;
    localparam int SAFE   = 0;

    logic       clk = 1'b0;
    logic       rst_n, enable, g_valid;
    logic [7:0] g_in;
    logic       pwm_a, tick_a, fault_a, clamp_a;
    logic [7:0] duty_a;
    logic       pwm_b, tick_b, fault_b, clamp_b;
    logic [7:0] duty_b;

    logic       sel;
    logic       obs_pwm, obs_tick, obs_fault, obs_clamp;
    logic [7:0] obs_duty;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    heater_pwm_driver #(.PERIOD(PA), .SLEW_MAX(SLEW_A), .WDOG_PERIODS(WD), .SAFE_DUTY(SAFE)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .g_valid(g_valid), .g_in(g_in),
        .pwm_out(pwm_a), .period_tick(tick_a), .duty_applied(duty_a),
        .wdog_fault(fault_a), .clamp_err(clamp_a)
    );

    heater_pwm_driver #(.PERIOD(PB), .SLEW_MAX(0), .WDOG_PERIODS(WD), .SAFE_DUTY(SAFE)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .g_valid(g_valid), .g_in(g_in),
        .pwm_out(pwm_b), .period_tick(tick_b), .duty_applied(duty_b),
        .wdog_fault(fault_b), .clamp_err(clamp_b)
    );

    assign obs_pwm   = sel ? pwm_b   : pwm_a;
    assign obs_tick  = sel ? tick_b  : tick_a;
    assign obs_duty  = sel ? duty_b  : duty_a;
    assign obs_fault = sel ? fault_b : fault_a;
    assign obs_clamp = sel ? clamp_b : clamp_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Starts on a period_tick cycle, runs to the next one; optionally strobes gi at cycle 10.
    task automatic run_period(input int p, input bit send, input logic [7:0] gi,
                              output int duty, output int highs, output int len,
                              output int clamps, output bit fault0, output bit fault_after);
        duty        = int'(obs_duty);
        fault0      = obs_fault;
        highs       = 0;
        len         = 0;
        clamps      = 0;
        fault_after = 1'b0;
        do begin
            highs  += int'(obs_pwm);
            clamps += int'(obs_clamp);
            if (len == 11) fault_after = obs_fault;
            g_valid = send && (len == 10);
            g_in    = gi;
            @(negedge clk);
            len++;
        end while (obs_tick !== 1'b1 && len < 4 * p);
        g_valid = 1'b0;
    endtask

    // Reference model: tracks position in the period, duty, and boundaries elapsed since the last command.
    int m_phase, m_duty, m_pend, m_silent;
    bit m_run, m_fs, m_fault, m_heard;
    bit e_pwm, e_tick, e_clamp;

    task automatic model_step(input bit r, input bit e, input bit v, input int gi);
        int  count, target, step;
        bit  bnd, trip;
        if (!r) begin
            m_run = 0; m_fs = 0; m_fault = 0; m_heard = 0;
            m_phase = 0; m_duty = 0; m_pend = 0; m_silent = 0;
            e_pwm = 0; e_tick = 0; e_clamp = 0;
            return;
        end
        e_clamp = v && (gi > 100);
        bnd     = m_run && e && (m_phase == PA - 1);
        trip    = 0;
        if (bnd) begin
            if (!v) m_silent++;
            count = v ? 0 : (m_heard ? m_silent - 1 : m_silent);
            if (count > WD) count = WD;
            trip   = !m_fs && (count >= WD);
            target = (m_fs || trip) ? SAFE : m_pend;
            step   = target - m_duty;
            if (SLEW_A > 0) begin
                if (step > SLEW_A) step = SLEW_A;
                if (step < -SLEW_A) step = -SLEW_A;
            end
            m_duty += step;
            if (trip) begin
                m_fs    = 1;
                m_fault = 1;
            end
        end
        if (!e) begin
            m_run = 0; m_fs = 0; m_phase = 0;
        end else if (!m_run) begin
            m_run = 1; m_phase = 0;
        end else begin
            m_phase = bnd ? 0 : m_phase + 1;
        end
        if (v) begin
            m_pend   = (gi > 100) ? 100 : gi;
            m_fault  = 0;
            m_fs     = 0;
            m_silent = 0;
            m_heard  = 1;
        end
        e_tick = m_run && (m_phase == 0);
        e_pwm  = m_run && (m_phase < (m_duty * PA) / 100);
    endtask

    typedef struct {
        logic [7:0] gi;
        int         duty;
        int         clamps;
        int         highs;
    } vec_t;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got 1, want 0");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t tbl[8];
        int   d, h, len, c, gv_div;
        bit   f0, fa, r;
        int   exp_d[8];
        bit   exp_f[8];

        tbl[0] = '{8'd50,  50,  0, 125};
        tbl[1] = '{8'd0,   0,   0, 0};
        tbl[2] = '{8'd101, 100, 1, 250};
        tbl[3] = '{8'd99,  99,  0, 247};
        tbl[4] = '{8'd255, 100, 1, 250};
        tbl[5] = '{8'd1,   1,   0, 2};
        tbl[6] = '{8'd100, 100, 0, 250};
        tbl[7] = '{8'd33,  33,  0, 82};
        exp_d = '{40, 40, 40, 40, 30, 20, 10, 0};
        exp_f = '{0, 0, 0, 0, 1, 1, 1, 1};

        sel = 1'b0; rst_n = 1'b0; enable = 1'b0; g_valid = 1'b0; g_in = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_pwm",   pwm_a,   0);
        check("reset_tick",  tick_a,  0);
        check("reset_duty",  duty_a,  0);
        check("reset_fault", fault_a, 0);
        check("reset_clamp", clamp_a, 0);

        // Slew up to 40 %, commanding every period.
        rst_n = 1'b1; enable = 1'b1;
        @(negedge clk);
        check("first_tick", obs_tick, 1);
        for (int k = 0; k < 5; k++) begin
            run_period(PA, 1, 8'd40, d, h, len, c, f0, fa);
            check($sformatf("slew_duty_%0d", k), d, k * 10);
            check($sformatf("slew_high_%0d", k), h, k * 10);
            check($sformatf("slew_len_%0d", k), len, PA);
        end

        // Commands stop: fault after four silent periods, ramp to 0, then recover.
        for (int i = 0; i < 8; i++) begin
            run_period(PA, i == 7, 8'd20, d, h, len, c, f0, fa);
            check($sformatf("wdog_duty_%0d", i), d, exp_d[i]);
            check($sformatf("wdog_fault_%0d", i), f0, exp_f[i]);
        end
        check("wdog_clear", fa, 0);
        run_period(PA, 0, 8'd0, d, h, len, c, f0, fa);
        check("recover_duty_1", d, 10);
        check("recover_fault", f0, 0);
        run_period(PA, 0, 8'd0, d, h, len, c, f0, fa);
        check("recover_duty_2", d, 20);

        // Out-of-range command clamps to 100 and ramps there; full-on periods have no gap.
        for (int i = 0; i < 10; i++) begin
            run_period(PA, 1, 8'd150, d, h, len, c, f0, fa);
            check($sformatf("clamp_duty_%0d", i), d, (20 + 10 * i > 100) ? 100 : 20 + 10 * i);
            check($sformatf("clamp_pulse_%0d", i), c, 1);
            check($sformatf("clamp_high_%0d", i), h, (20 + 10 * i > 100) ? 100 : 20 + 10 * i);
        end

        // Enable dropped at cnt 37, restored later.
        repeat (37) @(negedge clk);
        check("en_pre_pwm", obs_pwm, 1);
        enable = 1'b0;
        @(negedge clk);
        check("en_off_pwm", obs_pwm, 0);
        check("en_off_tick", obs_tick, 0);
        repeat (5) @(negedge clk);
        check("en_off_pwm_held", obs_pwm, 0);
        check("en_off_duty", obs_duty, 100);
        enable = 1'b1;
        @(negedge clk);
        check("en_on_tick", obs_tick, 1);
        check("en_on_duty", obs_duty, 100);
        check("en_on_pwm", obs_pwm, 1);

        // Reset in the high phase at duty 70.
        for (int i = 0; i < 3; i++) begin
            run_period(PA, 1, 8'd70, d, h, len, c, f0, fa);
            check($sformatf("down_duty_%0d", i), d, 100 - 10 * i);
        end
        check("at_70", obs_duty, 70);
        repeat (20) @(negedge clk);
        check("mid_high_pwm", obs_pwm, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_pwm", obs_pwm, 0);
        check("rst_tick", obs_tick, 0);
        check("rst_duty", obs_duty, 0);
        check("rst_fault", obs_fault, 0);
        check("rst_clamp", obs_clamp, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_tick", obs_tick, 1);
        check("restart_pwm", obs_pwm, 0);
        run_period(PA, 1, 8'd70, d, h, len, c, f0, fa);
        check("restart_duty_0", d, 0);
        run_period(PA, 0, 8'd0, d, h, len, c, f0, fa);
        check("restart_duty_1", d, 10);

        // No-slew instance, period 250: vector table.
        sel = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        check("b_reset_duty", obs_duty, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("b_first_tick", obs_tick, 1);
        for (int i = 0; i < 8; i++) begin
            run_period(PB, 1, tbl[i].gi, d, h, len, c, f0, fa);
            check($sformatf("tbl_clamp_%0d", i), c, tbl[i].clamps);
            run_period(PB, 0, 8'd0, d, h, len, c, f0, fa);
            check($sformatf("tbl_duty_%0d", i), d, tbl[i].duty);
            check($sformatf("tbl_high_%0d", i), h, tbl[i].highs);
            check($sformatf("tbl_len_%0d", i), len, PB);
        end

        // Command landing on the boundary cycle waits one more period.
        check("bnd_pre_duty", obs_duty, 33);
        repeat (PB - 1) @(negedge clk);
        g_valid = 1'b1; g_in = 8'd90;
        @(negedge clk);
        g_valid = 1'b0;
        check("bnd_tick", obs_tick, 1);
        check("bnd_duty_kept", obs_duty, 33);
        run_period(PB, 0, 8'd0, d, h, len, c, f0, fa);
        check("bnd_high_kept", h, 82);
        run_period(PB, 0, 8'd0, d, h, len, c, f0, fa);
        check("bnd_duty_new", d, 90);
        check("bnd_high_new", h, 225);

        // Randomized run against the reference model.
        sel = 1'b0; enable = 1'b1; gv_div = 60;
        for (int i = 0; i < 6000; i++) begin
            if (i % 1000 == 0) gv_div = ((i / 1000) % 2 == 1) ? 900 : 60;
            r = !((i == 0) || ($urandom_range(0, 1999) == 0));
            if ($urandom_range(0, 399) == 0) enable = !enable;
            g_valid = ($urandom_range(0, gv_div - 1) == 0);
            g_in    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 100)) : 8'($urandom_range(0, 255));
            rst_n   = r;
            model_step(r, enable, g_valid, int'(g_in));
            @(negedge clk);
            check($sformatf("rand_%0d", i), {pwm_a, tick_a, duty_a, fault_a, clamp_a},
                  {e_pwm, e_tick, 8'(m_duty), m_fault, e_clamp});
        end
        g_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
